// File: rtl/vc_dest_router_if.sv
// vc_dest_router_if: word/backpressure bundle between the referee
// and the destination FIFOs, as seen by the router.
interface vc_dest_router_if #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  almost_full_0;
  logic                  almost_full_1;
  logic                  almost_full_2;
  logic                  almost_full_3;
  logic                  push_0;
  logic                  push_1;
  logic                  push_2;
  logic                  push_3;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  stall;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  cnt_0;
  logic [CNT_WIDTH-1:0]  cnt_1;
  logic [CNT_WIDTH-1:0]  cnt_2;
  logic [CNT_WIDTH-1:0]  cnt_3;

  modport slave (
    input  data_in, valid_in,
    input  almost_full_0, almost_full_1,
    input  almost_full_2, almost_full_3,
    output push_0, push_1, push_2, push_3,
    output data_out, stall, overflow,
    output cnt_0, cnt_1, cnt_2, cnt_3
  );

  modport master (
    output data_in, valid_in,
    output almost_full_0, almost_full_1,
    output almost_full_2, almost_full_3,
    input  push_0, push_1, push_2, push_3,
    input  data_out, stall, overflow,
    input  cnt_0, cnt_1, cnt_2, cnt_3
  );
endinterface

// File: rtl/vc_dest_router.sv
// vc_dest_router: routes referee words to four destination FIFOs
// through an in-order skid buffer with head-of-line blocking.
module vc_dest_router #(
  parameter int DATA_WIDTH = 12,
  parameter int DEST_MSB   = 11,
  parameter int DEST_LSB   = 10,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_WIDTH  = 8
) (
  input logic            clk,
  input logic            reset,
  vc_dest_router_if.slave bus
);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW:0]           occ_q, occ_d;
  logic [3:0]            push_q, push_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q [4];
  logic [CNT_WIDTH-1:0]  cnt_d [4];
  logic                  ovf_q, ovf_d;

  logic [3:0]            af;
  logic [DATA_WIDTH-1:0] head;
  logic [1:0]            dest;
  logic                  buffered;
  logic                  head_vld;
  logic                  disp;
  logic                  rd_en;
  logic                  wr_en;
  logic                  bypass;

  assign af = {bus.almost_full_3, bus.almost_full_2,
               bus.almost_full_1, bus.almost_full_0};

  // The oldest buffered word always goes first; data_in only
  // bypasses when nothing is waiting ahead of it.
  assign buffered = (occ_q != '0);
  assign head     = buffered ? mem_q[rd_ptr_q] : bus.data_in;
  assign head_vld = buffered | bus.valid_in;
  assign dest     = head[DEST_MSB:DEST_LSB];
  assign disp     = head_vld & ~af[dest];
  assign rd_en    = disp & buffered;
  assign bypass   = disp & ~buffered;
  assign wr_en    = bus.valid_in & ~bypass &
                    ((occ_q != OCC_FULL) | rd_en);

  // Next-state: dispatch, pointer/occupancy bookkeeping, drop flag.
  always_comb begin
    push_d   = '0;
    data_d   = data_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q | (bus.valid_in & ~bypass & ~wr_en);
    if (disp) begin
      push_d[dest] = 1'b1;
      data_d       = head;
      cnt_d[dest]  = cnt_q[dest] + CNT_WIDTH'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + (PW+1)'(1);
      2'b01:   occ_d = occ_q - (PW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      push_q   <= push_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  // Skid storage; contents are meaningless while occupancy is 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.push_0   = push_q[0];
  assign bus.push_1   = push_q[1];
  assign bus.push_2   = push_q[2];
  assign bus.push_3   = push_q[3];
  assign bus.data_out = data_q;
  assign bus.overflow = ovf_q;
  assign bus.stall    = buffered | (|af);
  assign bus.cnt_0    = cnt_q[0];
  assign bus.cnt_1    = cnt_q[1];
  assign bus.cnt_2    = cnt_q[2];
  assign bus.cnt_3    = cnt_q[3];
endmodule

// File: tb/tb_vc_dest_router.sv
// tb_vc_dest_router: queue-based reference model with per-cycle
// compare, directed scenarios and randomized traffic.
module tb_vc_dest_router;
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        vin   = 1'b0;
  logic [11:0] din   = '0;
  logic [3:0]  afv   = '0;

  int n_pass  = 0;
  int n_total = 0;

  vc_dest_router_if #(.DATA_WIDTH(12), .CNT_WIDTH(8)) bus();

  assign bus.valid_in      = vin;
  assign bus.data_in       = din;
  assign bus.almost_full_0 = afv[0];
  assign bus.almost_full_1 = afv[1];
  assign bus.almost_full_2 = afv[2];
  assign bus.almost_full_3 = afv[3];

  vc_dest_router #(
    .DATA_WIDTH(12), .DEST_MSB(11), .DEST_LSB(10),
    .SKID_DEPTH(2), .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: a plain word queue of capacity 2.
  logic [11:0] q[$];
  logic [3:0]  exp_push = '0;
  logic [11:0] exp_data = '0;
  int          exp_cnt [4] = '{0, 0, 0, 0};
  bit          exp_ovf = 1'b0;

  always @(posedge clk or posedge reset) begin
    logic [11:0] h;
    bit          from_q;
    bit          used;
    int          d;
    if (reset) begin
      q.delete();
      exp_push = '0;
      exp_data = '0;
      exp_cnt  = '{0, 0, 0, 0};
      exp_ovf  = 1'b0;
    end else begin
      exp_push = '0;
      used     = 1'b0;
      from_q   = (q.size() > 0);
      h        = from_q ? q[0] : din;
      if (from_q || vin) begin
        d = int'(h[11:10]);
        if (!afv[d]) begin
          exp_push[d] = 1'b1;
          exp_data    = h;
          exp_cnt[d]  = (exp_cnt[d] + 1) % 256;
          if (from_q) void'(q.pop_front());
          else used = 1'b1;
        end
      end
      if (vin && !used) begin
        if (q.size() < 2) q.push_back(din);
        else exp_ovf = 1'b1;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic logic [3:0] dut_push();
    return {bus.push_3, bus.push_2, bus.push_1, bus.push_0};
  endfunction

  // Per-cycle compare against the model, away from the clock edge.
  always @(negedge clk) begin
    chk("m_push", 32'(dut_push()), 32'(exp_push));
    chk("m_data", 32'(bus.data_out), 32'(exp_data));
    chk("m_ovf", 32'(bus.overflow), 32'(exp_ovf));
    chk("m_stall", 32'(bus.stall),
        32'((q.size() != 0) || (afv != 0)));
    chk("m_cnt0", 32'(bus.cnt_0), 32'(exp_cnt[0]));
    chk("m_cnt1", 32'(bus.cnt_1), 32'(exp_cnt[1]));
    chk("m_cnt2", 32'(bus.cnt_2), 32'(exp_cnt[2]));
    chk("m_cnt3", 32'(bus.cnt_3), 32'(exp_cnt[3]));
  end

  task automatic step(input bit v, input logic [11:0] d,
                      input logic [3:0] a);
    vin = v;
    din = d;
    afv = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) step(0, 12'hFFF, 4'h0);
    chk("idle_push", 32'(dut_push()), 32'h0);
    chk("idle_data", 32'(bus.data_out), 32'h0);
    chk("idle_stall", 32'(bus.stall), 32'h0);
    chk("idle_cnt2", 32'(bus.cnt_2), 32'h0);

    // Single word, dest 2
    step(1, 12'h8A5, 4'h0);
    chk("one_push", 32'(dut_push()), 32'b0100);
    chk("one_data", 32'(bus.data_out), 32'h8A5);
    chk("one_cnt2", 32'(bus.cnt_2), 32'd1);
    step(0, 12'h0, 4'h0);
    chk("one_off", 32'(dut_push()), 32'h0);

    // Back-to-back to all four destinations
    step(1, 12'h012, 4'h0);
    chk("b2b_0", 32'(dut_push()), 32'b0001);
    step(1, 12'h412, 4'h0);
    chk("b2b_1", 32'(dut_push()), 32'b0010);
    step(1, 12'hC12, 4'h0);
    chk("b2b_3", 32'(dut_push()), 32'b1000);
    chk("b2b_d3", 32'(bus.data_out), 32'hC12);
    step(1, 12'h812, 4'h0);
    chk("b2b_2", 32'(dut_push()), 32'b0100);
    chk("b2b_cnt2", 32'(bus.cnt_2), 32'd2);
    step(0, 12'h0, 4'h0);

    // Head-of-line blocking on dest 1
    step(0, 12'h0, 4'b0010);
    chk("hol_stall0", 32'(bus.stall), 32'h1);
    step(1, 12'h400, 4'b0010);
    step(1, 12'h001, 4'b0010);
    chk("hol_nopush", 32'(dut_push()), 32'h0);
    step(0, 12'h0, 4'b0000);
    chk("hol_p1", 32'(dut_push()), 32'b0010);
    chk("hol_d1", 32'(bus.data_out), 32'h400);
    step(0, 12'h0, 4'b0000);
    chk("hol_p0", 32'(dut_push()), 32'b0001);
    chk("hol_d0", 32'(bus.data_out), 32'h001);
    step(0, 12'h0, 4'b0000);
    chk("hol_stall1", 32'(bus.stall), 32'h0);

    // Overflow on dest 3
    step(0, 12'h0, 4'b1000);
    step(1, 12'hC01, 4'b1000);
    step(1, 12'hC02, 4'b1000);
    step(1, 12'hC03, 4'b1000);
    chk("ovf_set", 32'(bus.overflow), 32'h1);
    step(0, 12'h0, 4'b0000);
    chk("ovf_p1", 32'(bus.data_out), 32'hC01);
    step(0, 12'h0, 4'b0000);
    chk("ovf_p2", 32'(bus.data_out), 32'hC02);
    step(0, 12'h0, 4'b0000);
    chk("ovf_none", 32'(dut_push()), 32'h0);
    chk("ovf_cnt3", 32'(bus.cnt_3), 32'd3);
    chk("ovf_hold", 32'(bus.overflow), 32'h1);

    // Reset, then counter wrap on dest 0
    reset = 1'b1;
    #1;
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 255; i++) step(1, 12'(i & 'h3FF), 4'h0);
    chk("wrap_255", 32'(bus.cnt_0), 32'd255);
    step(1, 12'h3FF, 4'h0);
    chk("wrap_0", 32'(bus.cnt_0), 32'd0);

    // Mid-burst reset with two words buffered
    step(1, 12'h001, 4'b0001);
    step(1, 12'h002, 4'b0001);
    chk("mid_stall", 32'(bus.stall), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_push", 32'(dut_push()), 32'h0);
    chk("mid_data", 32'(bus.data_out), 32'h0);
    chk("mid_cnt0", 32'(bus.cnt_0), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 12'h0, 4'h0);
      chk("mid_after", 32'(dut_push()), 32'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a;
      for (int b = 0; b < 4; b++) a[b] = ($urandom_range(0, 3) == 0);
      step(bit'($urandom_range(0, 1)), 12'($urandom), a);
    end
    for (int i = 0; i < 4; i++) step(0, 12'h0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
